// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus between the MEM stage, the load/store unit and memory.
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 32
`endif

interface load_store_unit_if #(
    parameter int unsigned ADDR_W = `DATA_MEM_ADDR_WIDTH
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [4:0]        resp_rd;
    logic              resp_err;

    logic              Mem_r;
    logic              Mem_w;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_W_Data;
    logic [3:0]        Mem_W_Strb;
    logic [31:0]       Mem_R_Data;

    // The unit side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, Mem_R_Data,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
               Mem_r, Mem_w, Mem_Addr, Mem_W_Data, Mem_W_Strb
    );

    // The pipeline/memory environment side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, Mem_R_Data,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
               Mem_r, Mem_w, Mem_Addr, Mem_W_Data, Mem_W_Strb
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits misaligned accesses into up to two word accesses,
// lane-shifts store data and reassembles/extends load data.
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 32
`endif

module load_store_unit #(
    parameter int unsigned ADDR_W = `DATA_MEM_ADDR_WIDTH
) (
    input logic               i_clk,
    input logic               i_rst,
    load_store_unit_if.slave  io_lsu
);
    localparam int unsigned WA = ADDR_W - 2;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_mem_r;
    logic            r_mem_w;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [3:0]      r_mem_strb;

    logic            r_we;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            r_cross;
    logic [4:0]      r_rd;
    logic [WA-1:0]   r_word;
    logic [3:0]      r_strb_hi;
    logic [DW-1:0]   r_wdata_hi;
    logic [DW-1:0]   r_raw;

    logic            r_resp_valid;
    logic            r_resp_err;
    logic [DW-1:0]   r_resp_rdata;
    logic [4:0]      r_resp_rd;

    logic [1:0]      w_off;
    logic [2:0]      w_n;
    logic [3:0]      w_mask;
    logic            w_legal;
    logic            w_cross;
    logic [7:0]      w_strb_wide;
    logic [63:0]     w_wdata_wide;
    logic [DW-1:0]   w_raw_next;
    logic [DW-1:0]   w_ext;

    // Request decode and lane placement; the upper half of each wide value feeds the second word.
    always_comb begin
        w_off   = io_lsu.req_addr[1:0];
        w_n     = 3'd4;
        w_mask  = 4'b1111;
        case (io_lsu.req_funct3[1:0])
            2'b00:   begin w_n = 3'd1; w_mask = 4'b0001; end
            2'b01:   begin w_n = 3'd2; w_mask = 4'b0011; end
            default: begin w_n = 3'd4; w_mask = 4'b1111; end
        endcase
        w_legal      = io_lsu.req_we ? (io_lsu.req_funct3 < 3'd3)
                                     : !(io_lsu.req_funct3 == 3'd3 || io_lsu.req_funct3 == 3'd6 ||
                                         io_lsu.req_funct3 == 3'd7);
        w_cross      = ({1'b0, w_off} + w_n) > 3'd4;
        w_strb_wide  = {4'b0000, w_mask} << w_off;
        w_wdata_wide = {32'd0, io_lsu.req_wdata} << {w_off, 3'b000};
    end

    // Load byte reassembly and extension of the response value.
    always_comb begin
        w_raw_next = io_lsu.Mem_R_Data >> {r_off, 3'b000};
        if (r_state == ACC1)
            w_raw_next = r_raw | (io_lsu.Mem_R_Data << (6'd32 - {1'b0, r_off, 3'b000}));
        case (r_f3)
            3'b000:  w_ext = {{24{w_raw_next[7]}}, w_raw_next[7:0]};
            3'b001:  w_ext = {{16{w_raw_next[15]}}, w_raw_next[15:0]};
            3'b100:  w_ext = {24'd0, w_raw_next[7:0]};
            3'b101:  w_ext = {16'd0, w_raw_next[15:0]};
            default: w_ext = w_raw_next;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_mem_r      <= 1'b0;
            r_mem_w      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_strb   <= '0;
            r_we         <= 1'b0;
            r_f3         <= '0;
            r_off        <= '0;
            r_cross      <= 1'b0;
            r_rd         <= '0;
            r_word       <= '0;
            r_strb_hi    <= '0;
            r_wdata_hi   <= '0;
            r_raw        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_rd    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_lsu.req_valid) begin
                        r_ready    <= 1'b0;
                        r_we       <= io_lsu.req_we;
                        r_f3       <= io_lsu.req_funct3;
                        r_off      <= w_off;
                        r_cross    <= w_cross;
                        r_rd       <= io_lsu.req_rd;
                        r_word     <= io_lsu.req_addr[ADDR_W-1:2];
                        r_strb_hi  <= w_strb_wide[7:4];
                        r_wdata_hi <= w_wdata_wide[63:32];
                        if (w_legal) begin
                            r_state     <= ACC0;
                            r_mem_r     <= !io_lsu.req_we;
                            r_mem_w     <= io_lsu.req_we;
                            r_mem_addr  <= {io_lsu.req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_strb  <= w_strb_wide[3:0];
                            r_mem_wdata <= w_wdata_wide[31:0];
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_rd    <= io_lsu.req_rd;
                        end
                    end
                end
                ACC0, ACC1: begin
                    r_raw <= w_raw_next;
                    if (r_state == ACC0 && r_cross) begin
                        r_state     <= ACC1;
                        r_mem_addr  <= {WA'(r_word + 1'b1), 2'b00};
                        r_mem_strb  <= r_strb_hi;
                        r_mem_wdata <= r_wdata_hi;
                    end else begin
                        r_state      <= RESP;
                        r_mem_r      <= 1'b0;
                        r_mem_w      <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_strb   <= '0;
                        r_mem_wdata  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? '0 : w_ext;
                        r_resp_rd    <= r_rd;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset must cut the handshake and enables in the same cycle so an in-flight write is dropped.
    assign io_lsu.req_ready  = r_ready & ~i_rst;
    assign io_lsu.Mem_r      = r_mem_r & ~i_rst;
    assign io_lsu.Mem_w      = r_mem_w & ~i_rst;
    assign io_lsu.Mem_Addr   = r_mem_addr;
    assign io_lsu.Mem_W_Data = r_mem_wdata;
    assign io_lsu.Mem_W_Strb = r_mem_strb;
    assign io_lsu.resp_valid = r_resp_valid;
    assign io_lsu.resp_rdata = r_resp_rdata;
    assign io_lsu.resp_rd    = r_resp_rd;
    assign io_lsu.resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, directed cases and random traffic.
module tb_load_store_unit;
    localparam int unsigned AW   = 6;
    localparam int unsigned MEMB = 64;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [7:0] mem     [MEMB];
    logic [7:0] ref_mem [MEMB];

    load_store_unit_if #(.ADDR_W(AW)) bus ();

    load_store_unit #(.ADDR_W(AW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_lsu (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: combinational read, strobed write at the clock edge.
    assign bus.Mem_R_Data = {mem[bus.Mem_Addr + 6'd3], mem[bus.Mem_Addr + 6'd2],
                             mem[bus.Mem_Addr + 6'd1], mem[bus.Mem_Addr]};
    always @(posedge clk) begin
        if (cyc < 3) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'h00;
        end else if (bus.Mem_w) begin
            for (int i = 0; i < 4; i++)
                if (bus.Mem_W_Strb[i]) mem[bus.Mem_Addr + 6'(i)] <= bus.Mem_W_Data[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: executes one request on the byte array; 'partial' keeps only bytes of the first word.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                                   input logic [31:0] wd, input logic [4:0] rd, input bit partial);
        exp_t e;
        int n, off;
        bit legal;
        logic [31:0] v;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr) % 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.rd  = rd;
        e.err = !legal;
        e.rdata = 32'd0;
        e.due = cyc + (!legal ? 1 : (off + n > 4) ? 3 : 2);
        if (legal && we) begin
            for (int i = 0; i < n; i++)
                if (!(partial && off + i >= 4)) ref_mem[(int'(addr) + i) % MEMB] = wd[8*i +: 8];
        end else if (legal) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(int'(addr) + i) % MEMB]) << (8 * i));
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            e.rdata = v;
        end
        return e;
    endfunction

    // Returns at the falling edge of the first cycle after acceptance (ACC0 for legal requests).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input bit hold, input bit abort);
        exp_t e;
        bit ok = 1'b0;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        bus.req_valid  = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (bus.req_ready) begin
                e = model(we, f3, addr, wd, rd, abort);
                if (!abort) sb.push_back(e);
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (hold) @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (bus.req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Response monitor and memory-bus invariants.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_rd", 32'(bus.resp_rd), 32'(e.rd));
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (bus.Mem_r || bus.Mem_w) begin
            check("mem_addr_align", 32'(bus.Mem_Addr[1:0]), 32'd0);
            check("mem_r_and_w", 32'(bus.Mem_r & bus.Mem_w), 32'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [2:0]  f3_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;

        repeat (4) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mem_w", 32'(bus.Mem_w), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_mem", {bus.Mem_W_Data[31:12], 2'(bus.Mem_r), 2'(bus.Mem_w), 2'(bus.Mem_Addr), bus.Mem_W_Strb},
              32'd0);
        check("post_rst_resp", 32'(bus.resp_valid), 32'd0);

        issue(1'b1, 3'd2, 6'h10, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0);
        check("sw_acc0_w", 32'(bus.Mem_w), 32'd1);
        check("sw_acc0_addr", 32'(bus.Mem_Addr), 32'h10);
        check("sw_acc0_strb", 32'(bus.Mem_W_Strb), 32'hF);
        check("sw_acc0_data", bus.Mem_W_Data, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 6'h10, 32'd0, 5'd2, 1'b0, 1'b0);

        issue(1'b1, 3'd0, 6'h13, 32'h000000A5, 5'd3, 1'b0, 1'b0);
        check("sb_strb", 32'(bus.Mem_W_Strb), 32'h8);
        check("sb_data", bus.Mem_W_Data, 32'hA5000000);
        issue(1'b0, 3'd0, 6'h13, 32'd0, 5'd4, 1'b0, 1'b0);
        issue(1'b0, 3'd4, 6'h13, 32'd0, 5'd5, 1'b0, 1'b0);

        issue(1'b1, 3'd1, 6'h23, 32'h00008001, 5'd6, 1'b0, 1'b0);
        check("sh_acc0_addr", 32'(bus.Mem_Addr), 32'h20);
        check("sh_acc0_strb", 32'(bus.Mem_W_Strb), 32'h8);
        check("sh_acc0_data", bus.Mem_W_Data, 32'h01000000);
        @(negedge clk);
        check("sh_acc1_w", 32'(bus.Mem_w), 32'd1);
        check("sh_acc1_addr", 32'(bus.Mem_Addr), 32'h24);
        check("sh_acc1_strb", 32'(bus.Mem_W_Strb), 32'h1);
        check("sh_acc1_data", bus.Mem_W_Data, 32'h00000080);
        issue(1'b0, 3'd1, 6'h23, 32'd0, 5'd7, 1'b0, 1'b0);

        issue(1'b1, 3'd2, 6'h3C, 32'h44332211, 5'd8, 1'b0, 1'b0);
        issue(1'b1, 3'd2, 6'h00, 32'h88776655, 5'd9, 1'b0, 1'b0);
        issue(1'b0, 3'd2, 6'h3E, 32'd0, 5'd10, 1'b0, 1'b0);
        check("wrap_acc0_addr", 32'(bus.Mem_Addr), 32'h3C);
        @(negedge clk);
        check("wrap_acc1_addr", 32'(bus.Mem_Addr), 32'h00);
        @(negedge clk);
        check("wrap_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("wrap_rdata", bus.resp_rdata, 32'h66554433);

        wait_idle();
        issue(1'b0, 3'd3, 6'h08, 32'd0, 5'd11, 1'b0, 1'b0);
        check("illegal_mem_r", 32'(bus.Mem_r), 32'd0);
        check("illegal_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("illegal_resp_err", 32'(bus.resp_err), 32'd1);
        issue(1'b1, 3'd5, 6'h08, 32'h12345678, 5'd12, 1'b1, 1'b0);
        issue(1'b1, 3'd2, 6'h08, 32'h0BADF00D, 5'd13, 1'b1, 1'b0);
        issue(1'b0, 3'd6, 6'h04, 32'd0, 5'd14, 1'b1, 1'b0);

        issue(1'b1, 3'd2, 6'h2E, 32'hCAFEF00D, 5'd15, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_mem_w", 32'(bus.Mem_w), 32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("abort_resp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(bus.req_ready), 32'd1);
        check("abort_resp_after", 32'(bus.resp_valid), 32'd0);
        issue(1'b0, 3'd2, 6'h2C, 32'd0, 5'd16, 1'b0, 1'b0);
        issue(1'b0, 3'd2, 6'h30, 32'd0, 5'd17, 1'b0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 15) < 14) f3 = we ? 3'($urandom_range(0, 2)) : f3_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom);
            issue(we, f3, 6'($urandom), $urandom, 5'($urandom), 1'b0, 1'b0);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < MEMB; i++) check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the MEM pipeline stage and the byte-addressed data memory. It accepts one load/store request at a time and drives the memory with word-aligned addresses, per-lane write strobes and lane-shifted write data. Accesses that cross a 4-byte word boundary are split into two memory cycles. Load bytes are reassembled, then sign- or zero-extended into a 32-bit result.

## Interface
- ADDR_W, default `DATA_MEM_ADDR_WIDTH`: byte-address width of the data memory.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag, echoed back on the response.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed tag.
- resp_err  out  1  illegal funct3.
- Mem_r  out  1  memory read enable.
- Mem_w  out  1  memory write enable.
- Mem_Addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- Mem_W_Data  out  32  lane-aligned write data.
- Mem_W_Strb  out  4  byte-lane write strobes.
- Mem_R_Data  in  32  combinational read data; valid in the same cycle Mem_r is high.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch all req_* fields.
  - Next state is ACC0 if funct3 is legal for the direction, else RESP with err = 1.
- ACC0
  - Access the first word: Mem_Addr = addr & ~3.
  - Next state is ACC1 if the access crosses a word boundary, else RESP.
- ACC1
  - Access the second word: Mem_Addr = (addr & ~3) + 4, wrapping modulo 2^ADDR_W.
  - Next state is RESP.
- RESP
  - resp_valid = 1 with registered rdata/rd/err.
  - Next state is IDLE.
- Lane arithmetic
  - off = addr[1:0]; n = 1/2/4 bytes; m = (1<<n) - 1.
  - The access crosses when off + n > 4.
  - ACC0: Strb = (m << off)[3:0], W_Data = wdata << 8·off.
  - ACC1: Strb = m >> (4 - off), W_Data = wdata >> 8·(4 - off).
- Load data
  - ACC0 captures Mem_R_Data >> 8·off into raw.
  - ACC1 ORs in Mem_R_Data << 8·(4 - off).
  - Entering RESP, the low n bytes of raw are extended: sign for LB/LH, zero for LBU/LHU, none for LW.
- Enables
  - Mem_r = load & (ACC0 | ACC1) & !rst.
  - Mem_w = store & (ACC0 | ACC1) & !rst.
  - Outside ACC states, Mem_Addr, W_Data and Strb are 0.
- Illegal funct3
  - Loads: 011, 110, 111. Stores: ≥ 011.
  - No memory access is made; resp_err = 1, resp_rdata = 0.
- Stores complete with resp_valid, resp_rdata = 0, resp_err = 0.

## Timing
- Reset
  - rst high at an edge forces state to IDLE and resp_valid/resp_rdata/resp_rd/resp_err to 0.
  - While rst is high: req_ready = 0 and Mem_r = Mem_w = 0.
  - After reset: req_ready = 1, all Mem_* outputs 0.
- Request accepted at edge E:
  - Non-crossing access: memory accessed in cycle E+1; resp_valid in cycle E+2.
  - Crossing access: memory accessed in E+1 and E+2; resp_valid in E+3.
  - Illegal funct3: resp_valid in E+1.
- Store bytes commit at the end of each ACC cycle.
- req_ready is 0 from E+1 until the cycle after RESP. Minimum request spacing is 3 cycles for non-crossing accesses and 4 for crossing ones.
- Reset during ACC1
  - The second-half write is suppressed.
  - The first-half write from ACC0 remains committed.
  - No response is produced.
- req_valid while req_ready = 0 is ignored. The requester holds the request until it is accepted.

## Test plan
- Reset, then SW addr 0x10, data 0xDEADBEEF -> ACC0: Addr 0x10, Strb 1111; resp_valid 2 cycles later; LW 0x10 returns 0xDEADBEEF.
- SB 0x13, data 0x000000A5 -> Strb 1000, W_Data 0xA5000000. LB 0x13 -> 0xFFFFFFA5. LBU 0x13 -> 0x000000A5.
- SH 0x23, data 0x8001 (crossing):
  - ACC0: Addr 0x20, Strb 1000, W_Data 0x01000000.
  - ACC1: Addr 0x24, Strb 0001, W_Data 0x00000080.
  - LH 0x23 -> 0xFFFF8001 at latency 3.
- LW 0x3E after word 0x3C = 0x44332211 and word 0x40 = 0x88776655 -> 0x66554433. The address of the last word wraps to 0.
- req_funct3 = 011 for a load -> no Mem_r, resp_err = 1 in the next cycle. Also check that req_valid held during busy cycles is not re-accepted.
- rst asserted during ACC1 of a crossing SW -> only the ACC0 lanes are written; resp_valid stays 0; req_ready = 1 after rst drops.
